// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: joystick bit positions and coin pulser states shared by the conditioner
package arcade_input_pkg;
  localparam int IDX_R  = 0;
  localparam int IDX_L  = 1;
  localparam int IDX_D  = 2;
  localparam int IDX_U  = 3;
  localparam int IDX_F1 = 4;
  localparam int IDX_S1 = 5;
  localparam int IDX_S2 = 6;
  localparam int IDX_CO = 7;
  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;
endpackage

// File: rtl/arcade_input_cond_debounce.sv
// input_debounce: single-bit debouncer, stable value flips after DEB_LEN consecutive differing ce samples
module input_debounce #(
  parameter int DEB_LEN = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic ce,
  input  logic d,
  output logic q
);
  logic [3:0] cnt;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (ce) begin
      if (d == q) cnt <= '0;
      else if (cnt == 4'(DEB_LEN - 1)) begin
        q   <= d;
        cnt <= '0;
      end else cnt <= cnt + 4'd1;
    end
endmodule

// File: rtl/arcade_input_cond.sv
// arcade_input_cond: sync + debounce of two joysticks, SOCD neutral, queued coin pulser; ARCADE_INPUT_AUTOFIRE_EN adds autofire
module arcade_input_cond
  import arcade_input_pkg::*;
#(
  parameter int DEB_LEN     = 4,
  parameter int COIN_FRAMES = 3,
  parameter int COIN_GAP    = 6,
  parameter int COIN_QMAX   = 3,
  parameter int AF_FRAMES   = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic       vblank,
  input  logic [7:0] joy0,
  input  logic [7:0] joy1,
  input  logic       af_en,
  output logic       right1,
  output logic       left1,
  output logic       fire1,
  output logic       right2,
  output logic       left2,
  output logic       fire2,
  output logic       start1,
  output logic       start2,
  output logic       coin1,
  output logic [1:0] coin_pending
);
  logic [16:0] s1, s2;
  logic [15:0] db;
  logic [1:0] fire;
  logic [3:0] fcnt;
  logic vb_q, vb_rise, co, co_q, ev, dec, done;
  coin_state_t state, nxt;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) {s2, s1} <= '0;
    else {s2, s1} <= {s1, vblank, joy1, joy0};
  for (genvar i = 0; i < 16; i++) begin : g_db
    input_debounce #(.DEB_LEN(DEB_LEN)) u_db (.clk_sys, .reset, .ce, .d(s2[i]), .q(db[i]));
  end
  assign vb_rise = s2[16] & ~vb_q;
  assign co      = db[IDX_CO] | db[8+IDX_CO];
  assign ev      = co & ~co_q;
  // opposing directions held together cancel to neutral
  assign right1  = db[IDX_R] & ~db[IDX_L];
  assign left1   = db[IDX_L] & ~db[IDX_R];
  assign right2  = db[8+IDX_R] & ~db[8+IDX_L];
  assign left2   = db[8+IDX_L] & ~db[8+IDX_R];
  assign start1  = db[IDX_S1] | db[8+IDX_S1];
  assign start2  = db[IDX_S2] | db[8+IDX_S2];
  assign fire1   = fire[0];
  assign fire2   = fire[1];
  assign coin1   = state == PULSE;
  always_comb begin
    dec  = state == IDLE && coin_pending != 2'd0;
    done = vb_rise && fcnt == (state == PULSE ? 4'(COIN_FRAMES - 1) : 4'(COIN_GAP - 1));
    nxt  = dec ? PULSE : !done ? state : state == PULSE ? GAP : IDLE;
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  // a full queue still accepts an event when a slot frees in the same cycle
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      vb_q         <= 1'b0;
      co_q         <= 1'b0;
      fcnt         <= '0;
      coin_pending <= '0;
    end else begin
      vb_q         <= s2[16];
      co_q         <= co;
      fcnt         <= (nxt != state || state == IDLE) ? 4'd0 : fcnt + 4'(vb_rise);
      coin_pending <= coin_pending + 2'(ev && (coin_pending != 2'(COIN_QMAX) || dec)) - 2'(dec);
    end
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  for (genvar p = 0; p < 2; p++) begin : g_af
    logic off;
    logic [3:0] cnt;
    always_ff @(posedge clk_sys or posedge reset)
      if (reset) {off, cnt} <= '0;
      else if (!db[8*p+IDX_F1]) {off, cnt} <= '0;
      else if (vb_rise) {off, cnt} <= cnt == 4'(AF_FRAMES - 1) ? {~off, 4'd0} : {off, cnt + 4'd1};
    assign fire[p] = db[8*p+IDX_F1] & ~(af_en & off);
  end
  logic unused;
  assign unused = ^{db[IDX_D], db[IDX_U], db[8+IDX_D], db[8+IDX_U]};
`else
  assign fire = {db[8+IDX_F1], db[IDX_F1]};
  logic unused;
  assign unused = ^{af_en, db[IDX_D], db[IDX_U], db[8+IDX_D], db[8+IDX_U]};
`endif
endmodule

// File: tb/tb_arcade_input_cond.sv
// tb_arcade_input_cond: randomized + directed bench against a frame-level behavioural model
module tb_arcade_input_cond;
  localparam int DEB_LEN = 4, COIN_FRAMES = 3, COIN_GAP = 6, COIN_QMAX = 3, AF_FRAMES = 4, P = 32;
  logic clk = 0, reset = 1, ce = 1, vblank = 0, af_en = 0;
  logic [7:0] joy0 = 0, joy1 = 0;
  logic right1, left1, fire1, right2, left2, fire2, start1, start2, coin1;
  logic [1:0] coin_pending;
  logic [10:0] dut_o;
  int errors = 0, checks = 0, cyc = 0;
  bit run = 0;

  arcade_input_cond #(.DEB_LEN(DEB_LEN), .COIN_FRAMES(COIN_FRAMES), .COIN_GAP(COIN_GAP),
                      .COIN_QMAX(COIN_QMAX), .AF_FRAMES(AF_FRAMES)) dut (
    .clk_sys(clk), .reset(reset), .ce(ce), .vblank(vblank), .joy0(joy0), .joy1(joy1), .af_en(af_en),
    .right1(right1), .left1(left1), .fire1(fire1), .right2(right2), .left2(left2), .fire2(fire2),
    .start1(start1), .start2(start2), .coin1(coin1), .coin_pending(coin_pending));

  assign dut_o = {right1, left1, fire1, right2, left2, fire2, start1, start2, coin1, coin_pending};
  always #5 clk = ~clk;

  // model: synced inputs, debounced bits, coin mode (0 idle,1 pulse,2 gap) with frames left, queue, fire hold frames
  logic [16:0] m_s1, m_s2;
  bit [15:0] m_st;
  int m_cnt[16];
  bit m_vbq, m_coq;
  int m_mode, m_left, m_q;
  int m_hold[2];

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_st = 0; m_vbq = 0; m_coq = 0;
    m_mode = 0; m_left = 0; m_q = 0; m_hold[0] = 0; m_hold[1] = 0;
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step();
    bit vr, ev, dec;
    if (reset) begin model_reset(); return; end
    vr  = m_s2[16] && !m_vbq;
    ev  = (m_st[7] || m_st[15]) && !m_coq;
    dec = m_mode == 0 && m_q > 0;
    if (dec) begin m_mode = 1; m_left = COIN_FRAMES; end
    else if (m_mode != 0 && vr) begin
      m_left--;
      if (m_left == 0) begin
        if (m_mode == 1) begin m_mode = 2; m_left = COIN_GAP; end
        else m_mode = 0;
      end
    end
    m_q = m_q - int'(dec) + int'(ev);
    if (m_q > COIN_QMAX) m_q = COIN_QMAX;
    for (int p = 0; p < 2; p++) m_hold[p] = m_st[8*p+4] ? m_hold[p] + int'(vr) : 0;
    m_vbq = m_s2[16];
    m_coq = m_st[7] || m_st[15];
    if (ce)
      for (int i = 0; i < 16; i++)
        if (m_s2[i] != m_st[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB_LEN) begin m_st[i] = m_s2[i]; m_cnt[i] = 0; end
        end else m_cnt[i] = 0;
    m_s2 = m_s1;
    m_s1 = {vblank, joy1, joy0};
  endtask

  function automatic logic mfire(int p);
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    return m_st[8*p+4] && !(af_en && (m_hold[p] / AF_FRAMES) % 2 == 1);
`else
    return m_st[8*p+4];
`endif
  endfunction

  function automatic logic [10:0] mdl_out();
    return {m_st[0] & !m_st[1], m_st[1] & !m_st[0], mfire(0), m_st[8] & !m_st[9], m_st[9] & !m_st[8], mfire(1),
            m_st[5] | m_st[13], m_st[6] | m_st[14], m_mode == 1, 2'(m_q)};
  endfunction

  always @(negedge clk)
    if (run) begin
      checks++;
      if (dut_o !== mdl_out()) begin
        errors++;
        $display("FAIL outs cyc=%0d dut=%b model=%b", cyc, dut_o, mdl_out());
      end
    end

  // coin waveform monitor for the directed frame-level checks
  int pulses = 0, hi_len = 0, low_len = 0, max_pend = 0;
  bit c_prev = 0, seen_fall = 0;
  logic [1:0] p_prev = 0;
  int highs[$], lows[$], plog[$];
  always @(negedge clk)
    if (run) begin
      if (coin1 && !c_prev) begin pulses++; if (seen_fall) lows.push_back(low_len); hi_len = 0; end
      if (!coin1 && c_prev) begin highs.push_back(hi_len); low_len = 0; seen_fall = 1; end
      if (coin1) hi_len++; else low_len++;
      if (coin_pending != p_prev) plog.push_back(int'(coin_pending));
      if (int'(coin_pending) > max_pend) max_pend = int'(coin_pending);
      c_prev = coin1;
      p_prev = coin_pending;
    end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      model_step();
      cyc++;
      vblank = (cyc % P) < 4;
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin errors++; $display("FAIL %s: got %0d expected %0d", nm, act, exp); end
  endtask

  function automatic int inr(int v, int lo, int hi);
    return int'(v >= lo && v <= hi);
  endfunction

  initial begin
    int h0, l0, p0, n0, k, fcnt, b;
    model_reset();
    tick(3);
    run = 1;
    check("reset_outs", int'(dut_o), 0);
    reset = 0;
    tick(2);
    joy0[0] = 1; tick(5); check("right_before_4th", int'(right1), 0);
    tick(1); check("right_at_4th", int'(right1), 1);
    joy0[0] = 0; tick(10);
    joy0[0] = 1; tick(3); joy0[0] = 0; tick(10); check("glitch_3", int'(right1), 0);
    joy0[1:0] = 2'b11; tick(10);
    check("socd_right", int'(right1), 0); check("socd_left", int'(left1), 0);
    joy0[1] = 0; tick(8);
    check("socd_rel_right", int'(right1), 1); check("socd_rel_left", int'(left1), 0);
    joy0 = 0; tick(10);
    h0 = highs.size(); l0 = lows.size(); p0 = plog.size(); n0 = pulses;
    joy0[7] = 1; tick(8); joy0[7] = 0; tick(24); joy0[7] = 1; tick(8); joy0[7] = 0; tick(700);
    check("two_pulses", pulses - n0, 2);
    check("pulse1_frames", inr(highs.size() > h0 ? highs[h0] : 0, 2*P+1, 3*P), 1);
    check("pulse2_frames", inr(highs.size() > h0+1 ? highs[h0+1] : 0, 2*P+1, 3*P), 1);
    check("gap_frames", inr(lows.size() > l0 ? lows[l0] : 0, 5*P+1, 6*P+1), 1);
    check("pend_seq_len", plog.size() - p0, 4);
    if (plog.size() - p0 >= 4)
      check("pend_seq", plog[p0]*1000 + plog[p0+1]*100 + plog[p0+2]*10 + plog[p0+3], 1010);
    n0 = pulses;
    repeat (5) begin joy0[7] = 1; tick(6); joy0[7] = 0; tick(6); end
    tick(1300);
    check("qmax_pulses", pulses - n0, 4);
    check("qmax_depth", max_pend, 3);
    joy0[7] = 1; tick(8); joy0[7] = 0;
    k = 0;
    while (!coin1 && k < 50) begin tick(1); k++; end
    check("coin_started", int'(coin1), 1);
    tick(10);
    #2 reset = 1; model_reset();
    #1 check("rst_coin1", int'(coin1), 0); check("rst_pend", int'(coin_pending), 0);
    n0 = pulses;
    tick(3); reset = 0; tick(400);
    check("no_pulse_after_rst", pulses - n0, 0);
    af_en = 1; joy0[4] = 1; tick(8);
    fcnt = 0;
    repeat (20*P) begin tick(1); fcnt += int'(fire1); end
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    check("af_duty", inr(fcnt, 8*P, 12*P), 1);
`else
    check("fire_const", fcnt, 20*P);
`endif
    joy0[4] = 0; tick(10); af_en = 0;
    repeat (3000) begin
      if ($urandom_range(7) == 0) begin
        b = $urandom_range(15);
        if (b < 8) joy0[b] = ~joy0[b]; else joy1[b-8] = ~joy1[b-8];
      end
      ce = $urandom_range(2) != 0;
      if ($urandom_range(99) == 0) af_en = ~af_en;
      tick(1);
    end
    joy0 = 0; joy1 = 0; ce = 1; tick(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
